seq_restoring_divider: RTL
==========================

// Module: seq_restoring_divider
// PURPOSE
//  Iterative unsigned restoring divider. It is the inverse datapath of the
//  MAC8 multiplier array and sits beside it in the arithmetic unit.
//  Computes quotient = dividend / divisor and remainder = dividend % divisor.
//  One quotient bit is produced per clock, with a start/busy/done handshake
//  toward the controller.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..16
// PORTS
//  clk        in   1      rising-edge clock (single clock domain)
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      request; sampled on rising clk edge only when not busy
//  dividend   in   WIDTH  unsigned; captured on the accepting edge
//  divisor    in   WIDTH  unsigned; captured on the accepting edge
//  busy       out  1      high while an operation is in progress
//  done       out  1      single-cycle pulse: results and dbz are valid
//  quotient   out  WIDTH  registered result; held until next completion
//  remainder  out  WIDTH  registered result; held until next completion
//  dbz        out  1      divide-by-zero flag of the last completed operation
// BEHAVIOUR
//  - Reset (async assert): state=IDLE; busy, done, dbz = 0;
//    quotient, remainder = 0; iteration counter = 0.
//  - Reset deasserts synchronously to clk.
//  - FSM states are IDLE, RUN and DONE. Encoding is free.
//  - IDLE/DONE with start=1 at edge E0:
//      - load Q = dividend, D = divisor, R = 0 ((WIDTH+1)-bit), cnt = 0;
//      - go to RUN; busy = 1 after E0.
//  - RUN, one iteration per edge:
//      - {R,Q} <<= 1;
//      - T = R - {1'b0,D};
//      - if T >= 0 (no borrow): R = T and Q[0] = 1, else Q[0] = 0;
//      - cnt++.
//  - The final iteration occurs on edge E0+WIDTH. On that same edge:
//      - quotient = Q, remainder = R[WIDTH-1:0], dbz = (D == 0);
//      - done = 1, busy = 0, state = DONE.
//  - DONE lasts exactly one cycle. done = 0 on the next edge; state returns
//    to IDLE unless start=1, in which case a new operation is accepted
//    (back-to-back, no bubble).
//  - Latency: start edge to done-high = WIDTH edges. Throughput is one
//    operation per WIDTH+1 cycles at most.
//  - start while busy=1 is ignored. Operands presented then are not
//    captured and the ongoing operation is unaffected.
//  - Operand inputs are don't-care except on the accepting edge.
//  - divisor = 0:
//      - runs the full WIDTH iterations; latency is unchanged;
//      - natural algorithm result: quotient = all ones, remainder = dividend;
//      - dbz = 1.
//    A nonzero-divisor completion clears dbz.
//  - dividend < divisor gives quotient = 0, remainder = dividend.
//    dividend = 0 gives 0/0 with dbz per divisor.
//  - quotient, remainder and dbz change only on a done edge or on reset.
//    They are stable while busy.
//  - Reset during RUN aborts immediately:
//      - no done pulse;
//      - outputs return to their reset values.
//  - Arithmetic is purely unsigned.
//  - The trial subtraction uses WIDTH+1 bits, so no overflow occurs for
//    any operand pair.
// TESTING
//  - 200/7 (WIDTH=8):
//      - start at E0; done at E8 only;
//      - quotient=28, remainder=4, dbz=0;
//      - busy high E0..E8 exclusive of done cycle.
//  - 255/1 -> quotient=255, remainder=0.
//    Then 3/9 -> quotient=0, remainder=3.
//    Then 0/5 -> 0, 0. All with dbz=0.
//  - 5/0 -> quotient=255, remainder=5, dbz=1 at E8.
//    Following 10/3 -> quotient=3, remainder=1, dbz cleared.
//  - Pulse start with 9/2 while busy (cycle E3) -> ignored; first result
//    (100/10 -> 10, 0) completes at E8 unaltered; no extra done.
//  - start held high in DONE cycle with 77/8 -> accepted; done at +8 edges
//    with quotient=9, remainder=5.
//    Async rst at E4 of a run -> immediate zeros, no done; next op 50/6
//    -> 8, 2.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero flag on completion.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic             load, finish;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_reg, d_reg;
  // Partial remainder always ends an iteration below the divisor, so it
  // fits in WIDTH bits; only the shifted trial value needs WIDTH+1.
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH:0]   shifted;
  logic             no_borrow;
  logic [WIDTH-1:0] r_next, q_next;

  always_comb begin
    shifted   = {r_reg, q_reg[WIDTH-1]};
    no_borrow = (shifted >= {1'b0, d_reg});
    r_next    = no_borrow ? WIDTH'(shifted - {1'b0, d_reg}) : shifted[WIDTH-1:0];
    q_next    = {q_reg[WIDTH-2:0], no_borrow};
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      q_reg <= dividend;
      d_reg <= divisor;
      r_reg <= '0;
    end else if (state == RUN) begin
      cnt   <= cnt + 1'b1;
      q_reg <= q_next;
      r_reg <= r_next;
      if (finish) begin
        quotient  <= q_next;
        remainder <= r_next;
        dbz       <= (d_reg == '0);
      end
    end
  end

endmodule
